iomem_router: RTL

Sequencing controller for the picosoc `iomem` port. It claims one 16 MB address page and splits it into up to 16 peripheral slots of 1 MB each. For each transaction it:
- raises exactly one slave-side valid,
- waits for that slave's ready,
- returns the read data to the CPU as a single-cycle ready pulse.

A watchdog timer completes any transaction the slave never acknowledges, so a missing or hung peripheral cannot stall the core. It sits between `soc.iomem_*` and the board peripherals (GPIO, future timers and UARTs).

---
 rtl/iomem_pkg.sv | 16 +
 rtl/iomem_router.sv | 139 +++++++++++++
 2 files changed

// File: rtl/iomem_pkg.sv
// Shared definitions for the picosoc iomem page router: FSM encoding,
// address-split constants and the default error read pattern.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int SLOT_BITS = 4;
  localparam int SLOT_SPAN = 20;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/iomem_router.sv
// Claims one 16 MB iomem page, forwards each request to one of up to 16
// 1 MB peripheral slots and guarantees completion with a watchdog.
module iomem_router
  import iomem_pkg::*;
#(
  parameter int          NSLOTS    = 4,
  parameter logic [7:0]  PAGE      = 8'h03,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [3:0]             m_wstrb,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  output logic [31:0]            m_rdata,
  output logic [NSLOTS-1:0]      s_valid,
  input  logic [NSLOTS-1:0]      s_ready,
  output logic [3:0]             s_wstrb,
  output logic [SLOT_SPAN-1:0]   s_addr,
  output logic [31:0]            s_wdata,
  input  logic [32*NSLOTS-1:0]   s_rdata,
  output logic [7:0]             timeout_count
);

  localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t               r_state;
  logic [SLOT_BITS-1:0] r_slot;
  logic [TW-1:0]        r_timer;
  logic                 r_m_ready;
  logic [31:0]          r_m_rdata;
  logic [NSLOTS-1:0]    r_s_valid;
  logic [SLOT_SPAN-1:0] r_s_addr;
  logic [31:0]          r_s_wdata;
  logic [3:0]           r_s_wstrb;
  logic [7:0]           r_count;

  logic [SLOT_BITS-1:0] w_slot;
  logic                 w_hit;
  logic                 w_populated;
  logic [NSLOTS-1:0]    w_onehot;
  logic                 w_sel_ready;
  logic [31:0]          w_sel_rdata;
  logic [7:0]           w_count_inc;

  assign w_slot      = m_addr[SLOT_SPAN +: SLOT_BITS];
  assign w_hit       = m_valid && (m_addr[31:24] == PAGE);
  assign w_populated = int'(w_slot) < NSLOTS;
  assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  // Slot decode for the new request, and ready/data select for the latched slot.
  always_comb begin
    w_onehot    = '0;
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (w_slot == SLOT_BITS'(i)) begin
        w_onehot[i] = 1'b1;
      end
      if (r_slot == SLOT_BITS'(i)) begin
        w_sel_ready = s_ready[i];
        w_sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_timer   <= '0;
      r_m_ready <= 1'b0;
      r_m_rdata <= '0;
      r_s_valid <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wstrb <= '0;
      r_count   <= '0;
    end else begin
      r_m_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_slot    <= w_slot;
            r_s_addr  <= m_addr[SLOT_SPAN-1:0];
            r_s_wdata <= m_wdata;
            r_s_wstrb <= m_wstrb;
            if (w_populated) begin
              r_s_valid <= w_onehot;
              r_timer   <= '0;
              r_state   <= ST_ACTIVE;
            end else begin
              r_m_rdata <= ERR_RDATA;
              r_count   <= w_count_inc;
              r_m_ready <= 1'b1;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_ACTIVE: begin
          // A ready on the expiry cycle wins over the watchdog.
          if (w_sel_ready) begin
            r_m_rdata <= w_sel_rdata;
            r_s_valid <= '0;
            r_m_ready <= 1'b1;
            r_state   <= ST_RESP;
          end else if (r_timer == TLAST) begin
            r_m_rdata <= ERR_RDATA;
            r_s_valid <= '0;
            r_count   <= w_count_inc;
            r_m_ready <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_ready       = r_m_ready;
  assign m_rdata       = r_m_rdata;
  assign s_valid       = r_s_valid;
  assign s_addr        = r_s_addr;
  assign s_wdata       = r_s_wdata;
  assign s_wstrb       = r_s_wstrb;
  assign timeout_count = r_count;

endmodule
